// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-wide data memory; sub-word stores use read-modify-write.
// Optional MJ32_LSU_BOUNDS_CHECK_EN rejects word indices >= MEM_WORDS.
module load_store_unit #(
  parameter int MEM_WORDS = 4500
) (
  input  logic        C,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_re,
  output logic [31:0] mem_Ra,
  input  logic [31:0] mem_Dout,
  output logic        mem_we,
  output logic [31:0] mem_Wa,
  output logic [31:0] mem_Din
);
  typedef enum logic [2:0] {IDLE, LD, RMW_RD, ST_W, RESP} state_t;

  state_t      state;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] buf_q;    // holds wdata until RMW merge, then the word to write
  logic        legal, misal, oob, bad;
  logic [31:0] idx, shifted, ld_data, rmw_data;

  always_comb begin
    legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                   : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
            (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef MJ32_LSU_BOUNDS_CHECK_EN
    oob = ({2'b00, req_addr[31:2]} >= $unsigned(MEM_WORDS));
`else
    // Range compare is masked off so the index reaches memory unchanged.
    oob = 1'b0 & ({2'b00, req_addr[31:2]} >= $unsigned(MEM_WORDS));
`endif
    bad = !legal || misal || oob;
  end

  assign idx     = {2'b00, addr_q[31:2]};
  assign shifted = mem_Dout >> {addr_q[1:0], 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'h0, shifted[7:0]};
      3'b101:  ld_data = {16'h0, shifted[15:0]};
      default: ld_data = mem_Dout;
    endcase
    rmw_data = mem_Dout;
    if (f3_q[0]) begin
      if (addr_q[1]) rmw_data[31:16] = buf_q[15:0];
      else           rmw_data[15:0]  = buf_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'b00:   rmw_data[7:0]   = buf_q[7:0];
        2'b01:   rmw_data[15:8]  = buf_q[7:0];
        2'b10:   rmw_data[23:16] = buf_q[7:0];
        default: rmw_data[31:24] = buf_q[7:0];
      endcase
    end
  end

  // Handshake and memory strobes decode straight from the state register.
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_re    = (state == LD) || (state == RMW_RD);
  assign mem_Ra    = mem_re ? idx : 32'h0;
  assign mem_we    = (state == ST_W) && rst_n;
  assign mem_Wa    = (state == ST_W) ? idx : 32'h0;
  assign mem_Din   = (state == ST_W) ? buf_q : 32'h0;

  always_ff @(posedge C) begin
    if (!rst_n) begin
      state     <= IDLE;
      f3_q      <= 3'h0;
      addr_q    <= 32'h0;
      buf_q     <= 32'h0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          f3_q      <= req_funct3;
          addr_q    <= req_addr;
          buf_q     <= req_wdata;
          rsp_rdata <= 32'h0;
          rsp_err   <= bad;
          if (bad)                        state <= RESP;
          else if (!req_we)               state <= LD;
          else if (req_funct3 == 3'b010)  state <= ST_W;
          else                            state <= RMW_RD;
        end
        LD: begin
          rsp_rdata <= ld_data;
          state     <= RESP;
        end
        RMW_RD: begin
          buf_q <= rmw_data;
          state <= ST_W;
        end
        ST_W:    state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, random and directed requests.
module tb_load_store_unit;
  logic        C = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'h0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, rsp_valid, rsp_err, mem_re, mem_we;
  logic [31:0] rsp_rdata, mem_Ra, mem_Dout, mem_Wa, mem_Din;

  load_store_unit #(.MEM_WORDS(4500)) dut (
    .C(C), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_re(mem_re), .mem_Ra(mem_Ra), .mem_Dout(mem_Dout),
    .mem_we(mem_we), .mem_Wa(mem_Wa), .mem_Din(mem_Din)
  );

  always #5 C = ~C;

  // Attached data memory: combinational read, write on posedge.
  logic [31:0] dmem [0:8191];
  assign mem_Dout = dmem[mem_Ra[12:0]];
  always @(posedge C) if (mem_we) dmem[mem_Wa[12:0]] <= mem_Din;

  // Reference model state: flat byte array.
  logic [7:0] ref_bytes [0:32767];
  logic [32:0] exp_q [$];   // {err, rdata}
  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[{a[14:2], 2'b00} + i];
    return w;
  endfunction

  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output bit err, output logic [31:0] rd, output int lat, output int nre, output int nwe);
    int size;
    bit legal;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    err   = !legal || (addr % size != 0);
`ifdef MJ32_LSU_BOUNDS_CHECK_EN
    if ((addr / 4) >= 4500) err = 1'b1;
`endif
    rd = 32'h0; lat = 1; nre = 0; nwe = 0;
    if (err) return;
    if (!we) begin
      for (int i = 0; i < size; i++) rd = rd | (32'(ref_bytes[addr[14:0] + i]) << (8 * i));
      if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFFFFFF << (8 * size));
      lat = 2; nre = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[addr[14:0] + i] = wd[8*i +: 8];
      lat = (size == 4) ? 2 : 3; nre = (size == 4) ? 0 : 1; nwe = 1;
    end
  endtask

  // Monitor: every response must match the oldest expectation.
  always @(negedge C) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp rdata=%h err=%0b expected no response", rsp_rdata, rsp_err);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
        check("rsp_rdata", rsp_rdata, e[31:0]);
      end
    end
  end

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    bit err; logic [31:0] rd, exp_din; int lat, nre, nwe;
    int got = 0, cre = 0, cwe = 0, w = 0;
    bit busy_ok = 1'b1;
    logic [31:0] ra_s = 32'h0, wa_s = 32'h0, din_s = 32'h0;
    while (!req_ready && w < 20) begin @(negedge C); w++; end
    model(we, f3, addr, wd, err, rd, lat, nre, nwe);
    exp_din = ref_word(addr);
    exp_q.push_back({err, rd});
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge C); #1 req_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge C);
      if (req_ready) busy_ok = 1'b0;
      if (mem_re) begin cre++; ra_s = mem_Ra; end
      if (mem_we) begin cwe++; wa_s = mem_Wa; din_s = mem_Din; end
      if (rsp_valid) begin got = n; break; end
    end
    check($sformatf("latency a=%h f3=%0d we=%0b", addr, f3, we), got, lat);
    check("ready_low_while_busy", {31'h0, busy_ok}, 32'h1);
    check("mem_re_cycles", cre, nre);
    check("mem_we_cycles", cwe, nwe);
    if (nre > 0) check("mem_Ra", ra_s, addr >> 2);
    if (nwe > 0) begin
      check("mem_Wa", wa_s, addr >> 2);
      check("mem_Din", din_s, exp_din);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) dmem[i] = 32'h0;
    for (int i = 0; i < 32768; i++) ref_bytes[i] = 8'h0;
    repeat (3) @(negedge C);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'h0, rsp_err}, 32'h0);
    check("reset mem strobes", {30'h0, mem_re, mem_we}, 32'h0);
    check("reset mem_Ra|Wa|Din", mem_Ra | mem_Wa | mem_Din, 32'h0);
    rst_n = 1'b1;
    @(negedge C);

    // Directed sequence
    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    do_req(0, 3'b000, 32'h13, 32'h0);
    do_req(0, 3'b100, 32'h13, 32'h0);
    do_req(0, 3'b001, 32'h12, 32'h0);
    do_req(0, 3'b101, 32'h12, 32'h0);
    do_req(1, 3'b000, 32'h11, 32'h12345655);
    do_req(0, 3'b010, 32'h10, 32'h0);
    check("sb_rmw_word", dmem[4], 32'hDEAD55EF);
    do_req(0, 3'b010, 32'h12, 32'h0);
    do_req(1, 3'b001, 32'h13, 32'hFFFF);
    do_req(0, 3'b011, 32'h10, 32'h0);
    do_req(1, 3'b100, 32'h10, 32'h1);
    do_req(0, 3'b010, 32'h4650, 32'h0);
    do_req(0, 3'b010, 32'h464C, 32'h0);

    // Reset during ST_W of an SH
    do_req(1, 3'b010, 32'h20, 32'hA5A5C3C3);
    @(negedge C);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h20; req_wdata = 32'h7777;
    @(posedge C); #1 req_valid = 1'b0;
    @(negedge C);
    @(negedge C);
    check("st_w_reached", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1 check("mem_we_gated_by_reset", {31'h0, mem_we}, 32'h0);
    @(negedge C);
    rst_n = 1'b1;
    @(negedge C);
    check("ready_after_reset", {31'h0, req_ready}, 32'h1);
    check("word8_unchanged", dmem[8], 32'hA5A5C3C3);
    do_req(0, 3'b010, 32'h20, 32'h0);

    // Random traffic over a small window
    for (int k = 0; k < 150; k++) begin
      logic [2:0] f3; logic [31:0] a;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) a = a & ~((f3[1:0] == 2'd2) ? 32'h3 : (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
      if ($urandom_range(0, 3) == 0) f3 = {1'b0, 2'($urandom_range(0, 2))};
      do_req($urandom_range(0, 1) == 1, f3, a, $urandom);
    end
    repeat (3) @(negedge C);
    check("queue_drained", exp_q.size(), 0);
    for (int i = 0; i < 32; i++) check($sformatf("final_word%0d", i), dmem[i], ref_word(i * 4));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end
endmodule
